multicycle_main_fsm: RTL and testbench



---
 rtl/multicycle_main_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm
//   Control sequencer for a multi-cycle RV32 datapath. One memory port is
//   shared by instruction fetch and data access. One ALU is shared by PC
//   increment, address generation and branch compare. The sequencer walks
//   R-type, lw, sw and beq through fetch / decode / execute / memory /
//   writeback.
//
//   Memory accesses wait on mem_ready and are bounded by a timeout. The
//   block has a sticky trap state and a retired-instruction counter.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   OP              opcode from the instruction register (next-state only)
//   mem_ready       memory completes the current access this cycle
//   PCWrite         unconditional PC load
//   PCWriteCond     PC load qualified by ALU zero
//   IorD            memory address select (0 PC, 1 ALUOut)
//   MemRead         memory read request
//   MemWrite        memory write request
//   IRWrite         instruction register load
//   MemtoReg        writeback select (1 MDR)
//   ALUop           00 add, 01 sub/compare, 10 funct-decoded
//   ALUsrcA         0 PC, 1 rs1
//   ALUsrcB         00 rs2, 01 constant 4, 10 immediate
//   PCSource        0 ALU result, 1 ALUOut
//   RegWrite        register file write
//   trap            sticky; illegal opcode or memory timeout
//   trap_cause      0 illegal opcode, 1 timeout (valid while trap=1)
//   retired         completed-instruction count, wraps
module multicycle_main_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       OP,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic [1:0]       ALUop,
  output logic             ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic             PCSource,
  output logic             RegWrite,
  output logic             trap,
  output logic             trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] EXEC_R    = 4'd2;
  localparam logic [3:0] ALU_WB    = 4'd3;
  localparam logic [3:0] MEM_ADDR  = 4'd4;
  localparam logic [3:0] MEM_READ  = 4'd5;
  localparam logic [3:0] MEM_WB    = 4'd6;
  localparam logic [3:0] MEM_WRITE = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] TRAP      = 4'd9;

  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_BEQ = 7'd99;

  // TIMEOUT is limited to 1..255, so an 8-bit wait counter is enough.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [3:0] state, nextState;
  logic [7:0] waitCnt;
  logic       isWait;
  logic       timedOut;
  logic       enterTrap;
  logic       retireNow;

  // These states hold a memory access open until mem_ready is seen.
  assign isWait = (state == FETCH) || (state == MEM_READ) ||
                  (state == MEM_WRITE);

  // A late mem_ready on the last allowed cycle still completes the access.
  assign timedOut  = isWait && !mem_ready && (waitCnt == WAIT_LAST);
  assign enterTrap = (nextState == TRAP) && (state != TRAP);

  // An instruction counts as retired in its final cycle. An sw that is
  // still waiting on memory has not retired yet.
  assign retireNow = (state == ALU_WB) || (state == MEM_WB) ||
                     (state == BRANCH) ||
                     ((state == MEM_WRITE) && mem_ready);

  // Next-state logic. OP is only consulted here, so it never has a
  // combinational path to the control outputs.
  always_comb begin
    nextState = state;
    case (state)
      FETCH: begin
        if (mem_ready)     nextState = DECODE;
        else if (timedOut) nextState = TRAP;
      end
      DECODE: begin
        case (OP)
          OP_R:         nextState = EXEC_R;
          OP_LW, OP_SW: nextState = MEM_ADDR;
          OP_BEQ:       nextState = BRANCH;
          default:      nextState = TRAP;
        endcase
      end
      EXEC_R:   nextState = ALU_WB;
      ALU_WB:   nextState = FETCH;
      MEM_ADDR: nextState = (OP == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ: begin
        if (mem_ready)     nextState = MEM_WB;
        else if (timedOut) nextState = TRAP;
      end
      MEM_WB:   nextState = FETCH;
      MEM_WRITE: begin
        if (mem_ready)     nextState = FETCH;
        else if (timedOut) nextState = TRAP;
      end
      BRANCH:   nextState = FETCH;
      TRAP:     nextState = TRAP;
      // Unused encodings fall back to a fresh fetch.
      default:  nextState = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // The counter only advances while the access stays pending. It is cleared
  // on a completed access or on any state change, including entry to TRAP.
  always_ff @(posedge clk) begin
    if (reset)
      waitCnt <= '0;
    else if (isWait && !mem_ready && (nextState == state))
      waitCnt <= waitCnt + 8'd1;
    else
      waitCnt <= '0;
  end

  // Both trap flags are latched on entry to TRAP. Only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap       <= 1'b0;
      trap_cause <= 1'b0;
    end else if (enterTrap) begin
      trap       <= 1'b1;
      trap_cause <= timedOut;
    end
  end

  // The counter wraps naturally and never saturates. In TRAP, retireNow
  // is 0, so the value holds.
  always_ff @(posedge clk) begin
    if (reset)          retired <= '0;
    else if (retireNow) retired <= retired + CNT_W'(1);
  end

  // Control outputs depend on state, and on mem_ready in FETCH.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUop       = 2'b00;
    ALUsrcA     = 1'b0;
    ALUsrcB     = 2'b00;
    PCSource    = 1'b0;
    RegWrite    = 1'b0;
    case (state)
      FETCH: begin
        // PC+4 goes through the ALU. PC and IR load only when the fetch
        // actually returns data.
        MemRead = 1'b1;
        ALUsrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        ALUsrcB = 2'b10;
      end
      EXEC_R: begin
        ALUsrcA = 1'b1;
        ALUop   = 2'b10;
      end
      ALU_WB: begin
        RegWrite = 1'b1;
      end
      MEM_ADDR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      BRANCH: begin
        ALUsrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm.
// The driver pushes each cycle's expected state and counters as it drives
// the inputs. The negedge monitor pops one entry and compares it with the
// DUT outputs.
module tb_multicycle_main_fsm;
  localparam int TO = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    OP;
  logic          mem_ready;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, ALUsrcA, PCSource, RegWrite, trap, trap_cause;
  logic [1:0]    ALUop, ALUsrcB;
  logic [CW-1:0] retired;

  multicycle_main_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUop(ALUop), .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB), .PCSource(PCSource), .RegWrite(RegWrite),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_ALU_WB = 3;
  localparam int S_MADDR = 4, S_MREAD = 5, S_MEM_WB = 6, S_MWRITE = 7;
  localparam int S_BRANCH = 8, S_TRAP = 9;

  typedef struct {
    string tag;
    int    st;
    logic  mr;
    int    ret;
    logic  trp;
    logic  cause;
  } exp_t;

  exp_t sbq[$];
  int   nTests = 0;
  int   nFail  = 0;
  int   expRet = 0;
  logic expTrap = 1'b0;
  logic expCause = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected control word per state, taken from the state table.
  // Packing: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  //           ALUop[1:0],ALUsrcA,ALUsrcB[1:0],PCSource,RegWrite}
  function automatic logic [13:0] ctrlOf(input int st, input logic mr);
    logic pcw, pcwc, iod, mrd, mwr, irw, m2r, asa, pcs, rw;
    logic [1:0] aop, asb;
    {pcw, pcwc, iod, mrd, mwr, irw, m2r, asa, pcs, rw} = '0;
    aop = 2'b00; asb = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: asb = 2'b10;
      S_EXEC_R: begin asa = 1; aop = 2'b10; end
      S_ALU_WB: rw = 1;
      S_MADDR:  begin asa = 1; asb = 2'b10; end
      S_MREAD:  begin mrd = 1; iod = 1; end
      S_MEM_WB: begin rw = 1; m2r = 1; end
      S_MWRITE: begin mwr = 1; iod = 1; end
      S_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 1; end
      default:  ;
    endcase
    return {pcw, pcwc, iod, mrd, mwr, irw, m2r, aop, asa, asb, pcs, rw};
  endfunction

  wire [13:0] ctrlObs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                         IRWrite, MemtoReg, ALUop, ALUsrcA, ALUsrcB,
                         PCSource, RegWrite};

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, ".ctrl"},  32'(ctrlObs),    32'(ctrlOf(e.st, e.mr)));
      chk({e.tag, ".ret"},   32'(retired),    32'(e.ret));
      chk({e.tag, ".trap"},  32'(trap),       32'(e.trp));
      chk({e.tag, ".cause"}, 32'(trap_cause), 32'(e.cause));
    end
  end

  // Drives one cycle and queues its expectation. If 'done' is set, this
  // cycle completes an instruction, so later cycles expect retired+1.
  task automatic cyc(input string tag, input int st, input logic [6:0] op,
                     input logic mr, input bit done);
    exp_t e;
    OP = op; mem_ready = mr;
    e.tag = tag; e.st = st; e.mr = mr;
    e.ret = expRet; e.trp = expTrap; e.cause = expCause;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (done) expRet = (expRet + 1) % (1 << CW);
  endtask

  task automatic doReset();
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    expRet = 0; expTrap = 1'b0; expCause = 1'b0;
  endtask

  task automatic rtype(input string tag);
    cyc({tag, ".F"}, S_FETCH,  7'd51, 1, 0);
    cyc({tag, ".D"}, S_DECODE, 7'd51, 1, 0);
    cyc({tag, ".X"}, S_EXEC_R, 7'd51, 1, 0);
    cyc({tag, ".W"}, S_ALU_WB, 7'd51, 1, 1);
  endtask

  task automatic lw(input string tag, input int waits);
    cyc({tag, ".F"}, S_FETCH,  7'd3, 1, 0);
    cyc({tag, ".D"}, S_DECODE, 7'd3, 1, 0);
    cyc({tag, ".A"}, S_MADDR,  7'd3, 1, 0);
    for (int i = 0; i < waits; i++) cyc({tag, ".Rw"}, S_MREAD, 7'd3, 0, 0);
    cyc({tag, ".R"}, S_MREAD,  7'd3, 1, 0);
    cyc({tag, ".W"}, S_MEM_WB, 7'd3, 1, 1);
  endtask

  task automatic sw(input string tag);
    cyc({tag, ".F"}, S_FETCH,  7'd35, 1, 0);
    cyc({tag, ".D"}, S_DECODE, 7'd35, 1, 0);
    cyc({tag, ".A"}, S_MADDR,  7'd35, 1, 0);
    cyc({tag, ".M"}, S_MWRITE, 7'd35, 1, 1);
  endtask

  task automatic beq(input string tag);
    cyc({tag, ".F"}, S_FETCH,  7'd99, 1, 0);
    cyc({tag, ".D"}, S_DECODE, 7'd99, 1, 0);
    cyc({tag, ".B"}, S_BRANCH, 7'd99, 1, 1);
  endtask

  initial begin
    reset = 1'b1; OP = 7'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic instruction flows, starting from the post-reset state.
    rtype("r");
    lw("lw3", 3);
    sw("sw");
    beq("beq");

    // Illegal opcode: trap with cause 0. All controls stay 0 and retired
    // holds, whatever mem_ready does.
    cyc("ill.F", S_FETCH,  7'h7f, 1, 0);
    cyc("ill.D", S_DECODE, 7'h7f, 1, 0);
    expTrap = 1'b1; expCause = 1'b0;
    for (int i = 0; i < 22; i++)
      cyc("ill.T", S_TRAP, 7'(i), 1'($urandom_range(0, 1)), 0);
    doReset();
    cyc("rst.F", S_FETCH, 7'd51, 0, 0);

    // Fetch timeout: 15 stalled cycles in total, then trap with cause 1.
    for (int i = 0; i < TO - 1; i++) cyc("to.F", S_FETCH, 7'd51, 0, 0);
    expTrap = 1'b1; expCause = 1'b1;
    for (int i = 0; i < 3; i++) cyc("to.T", S_TRAP, 7'd51, 1, 0);
    doReset();

    // mem_ready on the 15th cycle wins over the timeout.
    for (int i = 0; i < TO - 1; i++) cyc("late.F", S_FETCH, 7'd99, 0, 0);
    beq("late");
    // The wait counter must restart for each access.
    for (int i = 0; i < TO - 1; i++) cyc("late2.F", S_FETCH, 7'd3, 0, 0);
    lw("late2", TO - 1);

    // Retired wraps from 15 to 0.
    doReset();
    for (int i = 0; i < 15; i++) beq("fill");
    beq("wrap");
    rtype("postwrap");

    // Reset during a stalled sw, with mem_ready high in the same cycle.
    cyc("rw.F", S_FETCH,  7'd35, 1, 0);
    cyc("rw.D", S_DECODE, 7'd35, 1, 0);
    cyc("rw.A", S_MADDR,  7'd35, 1, 0);
    cyc("rw.Mw", S_MWRITE, 7'd35, 0, 0);
    cyc("rw.Mw", S_MWRITE, 7'd35, 0, 0);
    reset = 1'b1;
    cyc("rw.Mr", S_MWRITE, 7'd35, 1, 0);
    reset = 1'b0;
    expRet = 0; expTrap = 1'b0; expCause = 1'b0;
    cyc("rw.F", S_FETCH, 7'd35, 0, 0);
    beq("after");

    @(negedge clk); #1;
    chk("sbq.empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
